// File: rtl/final_link_serializer.sv
// Serializes one wide arbitration-FIFO word into LSB-first link beats with a last marker.
// Holds one word and reloads on the last-beat handshake, so back-to-back words stream without bubbles.
module final_link_serializer #(
   parameter int HUB_FIFO_PHYSICAL_WIDTH = 128,
   parameter int LINK_WIDTH              = 32,
   parameter int COUNT_WIDTH             = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] final_fifo_out_data,
   input  logic                               final_fifo_out_valid,
   output logic                               final_fifo_out_ready,
   output logic [LINK_WIDTH-1:0]              link_data,
   output logic                               link_valid,
   output logic                               link_last,
   input  logic                               link_ready,
   output logic                               has_flying_messages,
   output logic [COUNT_WIDTH-1:0]             tx_word_count
);

   localparam int BEATS          = (HUB_FIFO_PHYSICAL_WIDTH + LINK_WIDTH - 1) / LINK_WIDTH;
   localparam int BEAT_IDX_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PAD_WIDTH      = BEATS * LINK_WIDTH;

   localparam logic IDLE = 1'b0;
   localparam logic SEND = 1'b1;

   localparam logic [BEAT_IDX_WIDTH-1:0] LAST_IDX = BEAT_IDX_WIDTH'(BEATS - 1);

   logic                               state;
   logic [BEAT_IDX_WIDTH-1:0]          beat_idx;
   logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] hold;
   logic [PAD_WIDTH-1:0]               hold_pad;
   logic [LINK_WIDTH-1:0]              beat_sel;
   logic                               sending;
   logic                               is_last;
   logic                               in_hs;
   logic                               out_hs;

   // Zero-extend so the final partial beat carries zeros above the word.
   always_comb begin
      hold_pad = '0;
      hold_pad[HUB_FIFO_PHYSICAL_WIDTH-1:0] = hold;
   end

   generate
      if (BEATS == 1) begin : g_single
         assign beat_sel = hold_pad;
      end else begin : g_multi
         logic [BEATS-1:0][LINK_WIDTH-1:0] beat_arr;
         assign beat_arr = hold_pad;
         assign beat_sel = beat_arr[beat_idx];
      end
   endgenerate

   assign sending = (state == SEND);
   assign is_last = sending & (beat_idx == LAST_IDX);
   assign out_hs  = sending & link_ready;
   assign in_hs   = final_fifo_out_valid & final_fifo_out_ready;

   // Ready is gated by reset so it reads 0 while reset is held.
   assign final_fifo_out_ready = reset & (~sending | (is_last & link_ready));
   assign link_valid           = sending;
   assign link_last            = is_last;
   assign link_data            = sending ? beat_sel : '0;
   assign has_flying_messages  = sending;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         beat_idx      <= '0;
         hold          <= '0;
         tx_word_count <= '0;
      end else begin
         if (out_hs) begin
            if (!is_last) begin
               beat_idx <= beat_idx + 1'b1;
            end else begin
               beat_idx <= '0;
               if (tx_word_count != '1)
                  tx_word_count <= tx_word_count + 1'b1;
               if (!in_hs)
                  state <= IDLE;
            end
         end
         // A new word can only arrive when idle or on the last-beat handshake.
         if (in_hs) begin
            hold     <= final_fifo_out_data;
            beat_idx <= '0;
            state    <= SEND;
         end
      end
   end

endmodule

// File: tb/tb_final_link_serializer.sv
// Bench for final_link_serializer: queue-of-beats model checked every cycle on the 32-bit link,
// plus directed literal checks, and a 48-bit link instance for padding and count saturation.
module tb_final_link_serializer;

   localparam int W   = 128;
   localparam int LW  = 32;
   localparam int NB  = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   data;
   logic           valid;
   logic           ready;
   logic [LW-1:0]  ldata;
   logic           lvalid;
   logic           llast;
   logic           lready;
   logic           fly;
   logic [15:0]    cnt;

   logic [W-1:0]   data2;
   logic           valid2;
   logic           ready2;
   logic [47:0]    ldata2;
   logic           lvalid2;
   logic           llast2;
   logic           lready2;
   logic           fly2;
   logic [1:0]     cnt2;

   final_link_serializer #(.HUB_FIFO_PHYSICAL_WIDTH(W), .LINK_WIDTH(LW), .COUNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .final_fifo_out_data(data), .final_fifo_out_valid(valid), .final_fifo_out_ready(ready),
      .link_data(ldata), .link_valid(lvalid), .link_last(llast), .link_ready(lready),
      .has_flying_messages(fly), .tx_word_count(cnt)
   );

   final_link_serializer #(.HUB_FIFO_PHYSICAL_WIDTH(W), .LINK_WIDTH(48), .COUNT_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset),
      .final_fifo_out_data(data2), .final_fifo_out_valid(valid2), .final_fifo_out_ready(ready2),
      .link_data(ldata2), .link_valid(lvalid2), .link_last(llast2), .link_ready(lready2),
      .has_flying_messages(fly2), .tx_word_count(cnt2)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct packed {
      logic [LW-1:0] d;
      logic          l;
   } beat_t;

   beat_t        q[$];
   int           mcount;
   logic [LW-1:0] obs_d[$];
   logic         obs_l[$];
   int           obs_c[$];
   int           acc_c[$];
   int           fly_cnt;
   logic [47:0]  obs2_d[$];
   logic         obs2_l[$];

   logic          ev, el, er, ohs, ihs;
   logic [LW-1:0] ed;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: the word in flight is a queue of pending beats; the front is what the link must show.
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         q.delete();
         mcount = 0;
      end
      ev = (q.size() > 0);
      ed = ev ? q[0].d : '0;
      el = ev ? q[0].l : 1'b0;
      er = reset && (!ev || (el && lready));
      chk("link_valid", lvalid, ev);
      chk("link_data", ldata, ed);
      chk("link_last", llast, el);
      chk("fifo_ready", ready, er);
      chk("flying", fly, ev);
      chk("tx_word_count", cnt, mcount);
      if (fly) fly_cnt++;
      if (reset) begin
         ohs = ev && lready;
         ihs = valid && er;
         if (lvalid && lready) begin
            obs_d.push_back(ldata);
            obs_l.push_back(llast);
            obs_c.push_back(cyc);
         end
         if (valid && ready) acc_c.push_back(cyc);
         if (lvalid2 && lready2) begin
            obs2_d.push_back(ldata2);
            obs2_l.push_back(llast2);
         end
         if (ohs) begin
            if (el && mcount < 65535) mcount++;
            void'(q.pop_front());
         end
         if (ihs)
            for (int i = 0; i < NB; i++)
               q.push_back('{d: data[i*LW +: LW], l: (i == NB-1)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      obs_d.delete(); obs_l.delete(); obs_c.delete(); acc_c.delete();
      obs2_d.delete(); obs2_l.delete();
      fly_cnt = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      clear_logs();
   endtask

   task automatic push_word(input logic [W-1:0] w);
      bit done = 0;
      data  = w;
      valid = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         @(negedge clk);
         if (ready) done = 1;
         tick();
      end
      valid = 1'b0;
      data  = '0;
      chk("push_accept", done, 1'b1);
   endtask

   task automatic push2(input logic [W-1:0] w);
      bit done = 0;
      data2  = w;
      valid2 = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         @(negedge clk);
         if (ready2) done = 1;
         tick();
      end
      valid2 = 1'b0;
      data2  = '0;
      chk("push2_accept", done, 1'b1);
   endtask

   task automatic wait_idle(input bit second);
      bit done = 0;
      for (int t = 0; t < 64 && !done; t++) begin
         @(negedge clk);
         if (second ? !fly2 : !fly) done = 1;
         tick();
      end
      chk("drain", done, 1'b1);
   endtask

   logic [LW-1:0] exp8[8];
   logic [W-1:0]  wd, we;

   initial begin
      reset   = 1'b0;
      data    = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
      valid   = 1'b1;
      lready  = 1'b1;
      data2   = '0;
      valid2  = 1'b0;
      lready2 = 1'b1;

      // Reset held with valid driven: everything quiet, ready low.
      @(negedge clk);
      chk("rst_ready", ready, 1'b0);
      chk("rst_link_valid", lvalid, 1'b0);
      chk("rst_link_data", ldata, '0);
      chk("rst_link_last", llast, 1'b0);
      chk("rst_cnt", cnt, '0);
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = '0;
      reset = 1'b1;
      #1;
      chk("rel_ready", ready, 1'b1);
      chk("rel_link_valid", lvalid, 1'b0);
      tick();

      // Single word, link always ready.
      clear_logs();
      push_word(128'h0000000F_0000000E_0000000D_0000000C);
      wait_idle(0);
      chk("t1_nbeats", obs_d.size(), 4);
      if (obs_d.size() == 4) begin
         exp8[0] = 32'h0C; exp8[1] = 32'h0D; exp8[2] = 32'h0E; exp8[3] = 32'h0F;
         for (int i = 0; i < 4; i++) begin
            chk("t1_beat", obs_d[i], exp8[i]);
            chk("t1_last", obs_l[i], (i == 3));
            chk("t1_contig", obs_c[i], acc_c[0] + 1 + i);
         end
      end
      chk("t1_count", cnt, 16'd1);
      chk("t1_fly_cycles", fly_cnt, 4);

      // Two words back to back.
      do_reset();
      push_word(128'h00000013_00000012_00000011_00000010);
      push_word(128'h00000023_00000022_00000021_00000020);
      wait_idle(0);
      chk("t2_nbeats", obs_d.size(), 8);
      chk("t2_naccept", acc_c.size(), 2);
      if (obs_d.size() == 8 && acc_c.size() == 2) begin
         exp8 = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20, 32'h21, 32'h22, 32'h23};
         for (int i = 0; i < 8; i++) begin
            chk("t2_beat", obs_d[i], exp8[i]);
            chk("t2_contig", obs_c[i], obs_c[0] + i);
         end
         chk("t2_reload_on_last", acc_c[1], obs_c[3]);
      end
      chk("t2_count", cnt, 16'd2);

      // Link back-pressure 1,0,0 repeating.
      do_reset();
      push_word(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
      for (int k = 0; k < 12; k++) begin
         lready = (k % 3 == 0);
         tick();
      end
      lready = 1'b1;
      wait_idle(0);
      chk("t3_nbeats", obs_d.size(), 4);
      if (obs_d.size() == 4) begin
         exp8[0] = 32'hA0A0A0A0; exp8[1] = 32'hA1A1A1A1;
         exp8[2] = 32'hA2A2A2A2; exp8[3] = 32'hA3A3A3A3;
         for (int i = 0; i < 4; i++) begin
            chk("t3_beat", obs_d[i], exp8[i]);
            chk("t3_spacing", obs_c[i] - obs_c[0], 3 * i);
         end
      end

      // Reset mid-word after the first beat is taken.
      do_reset();
      wd = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
      we = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
      push_word(wd);
      tick();
      reset = 1'b0;
      #1;
      chk("t4_valid_drop", lvalid, 1'b0);
      chk("t4_fly_drop", fly, 1'b0);
      chk("t4_cnt_clear", cnt, '0);
      chk("t4_pre_beats", obs_d.size(), 1);
      if (obs_d.size() == 1) chk("t4_pre_beat0", obs_d[0], 32'hD0D0D0D0);
      tick();
      reset = 1'b1;
      clear_logs();
      push_word(we);
      wait_idle(0);
      chk("t4_nbeats", obs_d.size(), 4);
      if (obs_d.size() == 4) begin
         chk("t4_restart_beat0", obs_d[0], 32'hE0E0E0E0);
         chk("t4_beat3", obs_d[3], 32'hE3E3E3E3);
      end
      chk("t4_count", cnt, 16'd1);

      // 48-bit link: 3 beats, last zero-padded; 2-bit counter saturates.
      do_reset();
      push2(128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4);
      wait_idle(1);
      chk("t5_nbeats", obs2_d.size(), 3);
      if (obs2_d.size() == 3) begin
         chk("t5_beat0", obs2_d[0], 48'hC3C4_D1D2D3D4);
         chk("t5_beat1", obs2_d[1], 48'hB1B2B3B4_C1C2);
         chk("t5_beat2_pad", obs2_d[2], 48'h0000_A1A2A3A4);
         chk("t5_last0", obs2_l[0], 1'b0);
         chk("t5_last2", obs2_l[2], 1'b1);
      end
      chk("t5_count1", cnt2, 2'd1);
      push2(128'h1);
      push2(128'h2);
      push2(128'h3);
      wait_idle(1);
      chk("t5_nbeats_total", obs2_d.size(), 12);
      chk("t5_count_sat", cnt2, 2'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/final_link_serializer.md
Name: final_link_serializer

Overview:
- Sits directly downstream of the final arbitration unit.
- Consumes its HUB_FIFO_PHYSICAL_WIDTH-wide final FIFO output words and serializes each into LINK_WIDTH-wide beats for the inter-FPGA link transmitter, LSB beat first, with a last-beat marker.
- Holds one word and accepts the next word in the same cycle the current word's last beat is taken, so back-to-back words stream at full link throughput.
- Reports in-flight state for the global quiescence (has_flying_messages) reduction.

Parameters:
- HUB_FIFO_PHYSICAL_WIDTH, 128, width of one input word (excludes valid/ready).
- LINK_WIDTH, 32, width of one output beat; must satisfy 1 <= LINK_WIDTH <= HUB_FIFO_PHYSICAL_WIDTH.
- COUNT_WIDTH, 16, width of the transmitted-word counter.
- Derived localparam BEATS = ceil(HUB_FIFO_PHYSICAL_WIDTH / LINK_WIDTH).
- Derived localparam BEAT_IDX_WIDTH = max(1, clog2(BEATS)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- final_fifo_out_data  input  HUB_FIFO_PHYSICAL_WIDTH  word from the arbitration unit.
- final_fifo_out_valid  input  1  word valid.
- final_fifo_out_ready  output  1  this block accepts the word.
- link_data  output  LINK_WIDTH  current beat.
- link_valid  output  1  beat valid.
- link_last  output  1  current beat is the final beat of its word.
- link_ready  input  1  link transmitter accepts the beat.
- has_flying_messages  output  1  a word is held or partially sent.
- tx_word_count  output  COUNT_WIDTH  number of words whose last beat has been handed off (saturating).

Behaviour:
- State: IDLE, SEND. The hold register is HUB_FIFO_PHYSICAL_WIDTH bits. beat_idx is BEAT_IDX_WIDTH bits. tx_word_count is COUNT_WIDTH bits.
- While reset=0, asynchronously:
  - state=IDLE, beat_idx=0, hold=0, tx_word_count=0.
  - Outputs: link_valid=0, link_last=0, link_data=0, final_fifo_out_ready=0, has_flying_messages=0.
- Out of reset, final_fifo_out_ready = (state==IDLE) | (state==SEND & link_last & link_ready). This is combinational from state and link_ready.
- An input handshake occurs when final_fifo_out_valid & final_fifo_out_ready. It loads hold, sets beat_idx=0 and moves to SEND. The first beat is presented the next cycle (1-cycle latency).
- In SEND:
  - link_valid=1.
  - link_data = hold[beat_idx*LINK_WIDTH +: LINK_WIDTH]. Bits beyond HUB_FIFO_PHYSICAL_WIDTH on the final beat are driven 0 (zero-padded).
  - link_last = (beat_idx == BEATS-1).
- Output handshake when link_valid & link_ready:
  - If not last: beat_idx increments.
  - If last and an input handshake occurs in the same cycle: reload hold, beat_idx=0, stay in SEND. There is no bubble.
  - If last and no input handshake: go to IDLE, beat_idx=0.
  - On any last-beat handshake, tx_word_count increments, saturating at all-ones.
- When link_valid=1 and link_ready=0, link_data, link_last and link_valid hold stable. link_valid never drops without a handshake, except on reset.
- In IDLE: link_valid=0, link_last=0, link_data=0.
- has_flying_messages = (state==SEND).
- BEATS==1 (LINK_WIDTH >= HUB_FIFO_PHYSICAL_WIDTH): every beat is last. The block acts as a one-deep pipeline register with full throughput.
- final_fifo_out_data is ignored when no input handshake occurs.
- Reset asserted mid-word: the held word is discarded and no further beats are emitted. Output resumes only with a new input word after reset deasserts.

Test Plan:
- Reset with reset=0 and the valid input driven -> all outputs 0, final_fifo_out_ready=0. Release reset -> final_fifo_out_ready=1 the same cycle, link_valid=0.
- Single word 0x0000000F_0000000E_0000000D_0000000C, link_ready=1 -> beats 0x0C,0x0D,0x0E,0x0F on 4 consecutive cycles starting 1 cycle after accept. link_last only on 0x0F. tx_word_count=1. has_flying_messages high exactly 4 cycles.
- Two back-to-back words, input valid held, link_ready=1 -> 8 contiguous beats with no idle cycle. final_fifo_out_ready pulses on the first-word last-beat cycle. tx_word_count=2.
- link_ready toggled 1,0,0,1,... during a word -> each beat is held stable while link_ready=0. No beat is dropped or duplicated, and the order is preserved.
- Reset pulsed after beat 1 of a word -> link_valid=0 immediately, count=0. The next word after release restarts at beat 0.
- LINK_WIDTH=48, HUB_FIFO_PHYSICAL_WIDTH=128 -> BEATS=3. Third beat carries bits [127:96] with the upper 16 bits 0.
